seq_det_prog: RTL and testbench
===============================

Name: seq_det_prog

Overview:
- Programmable serial sequence detector; successor to the fixed 12-bit pattern detector.
- Pattern, length (1..MAX_LEN), per-bit don't-care mask and overlap/non-overlap mode are runtime-loadable.
- Serial input is qualified by a sample-valid strobe. The block keeps a saturating count of matches.
- Sits on serial bitstream paths (frame-sync / preamble hunt) ahead of deframing logic.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits (>=2); sets shift register and pattern/mask width.
- CNT_W, 8, width of the match counter.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- x_i  input  1  serial data bit.
- valid_i  input  1  x_i is a sample this cycle.
- cfg_load_i  input  1  latch cfg_* into internal config registers.
- cfg_pattern_i  input  MAX_LEN  pattern; bit 0 = most recently received bit.
- cfg_mask_i  input  MAX_LEN  1 = compare this bit, 0 = don't care.
- cfg_len_i  input  LEN_W  pattern length; 0 = disabled.
- cfg_overlap_i  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
- clear_i  input  1  synchronous clear of match counter.
- det_o  output  1  registered one-cycle match pulse.
- cnt_o  output  CNT_W  saturating match count.
- armed_o  output  1  1 while in HUNT state.

Behaviour:
- Reset (reset=0): shift_ff=0, fill_ff=0, all config registers=0, state=IDLE, det_o=0, cnt_o=0, armed_o=0.
- Config registers: pat_ff, mask_ff, len_ff, ovl_ff.
  - Loaded on the rising edge with cfg_load_i=1.
  - cfg_len_i > MAX_LEN is clamped to MAX_LEN.
- Shift: on each edge with valid_i=1 (and no load), shift_ff <= {shift_ff[MAX_LEN-2:0], x_i}. Without valid_i, shift_ff holds.
- Match condition on the next shift value nxt: for all i < len_ff, mask_ff[i]=0 or nxt[i]==pat_ff[i]. Bits i >= len_ff are ignored.
- fill_ff counts valid samples since arm, saturating at len_ff.
- FSM:
  - IDLE: len_ff==0. No detection; shift still captures samples. Goes to FILL on a load with nonzero length.
  - FILL: fill_ff < len_ff. On a valid sample, fill_ff increments. When the incremented value equals len_ff, go to HUNT and evaluate the match on this same sample.
  - HUNT: every valid sample is evaluated. On a match with ovl_ff=0, fill_ff <= 0 and the state returns to FILL, so the next match needs len_ff fresh samples. On a match with ovl_ff=1, the state stays in HUNT.
- det_o:
  - Asserted for exactly the one cycle after the clock edge that captured the completing sample, i.e. registered, latency 1 edge.
  - 0 in every other cycle, including cycles with valid_i=0.
- cnt_o:
  - Increments on each det_o assertion edge (same edge det_o is set).
  - Saturates at 2^CNT_W-1.
- clear_i: cnt_o <= 0. If clear_i coincides with a match, clear wins (cnt_o=0) but det_o still pulses.
- cfg_load_i priority:
  - Over valid_i: the sample that cycle is discarded.
  - shift_ff <= 0 and fill_ff <= 0; state <= FILL (or IDLE if the new length is 0); det_o <= 0.
  - cnt_o is unaffected.
- len_ff=1: FILL lasts one sample; a single-bit match fires on every qualifying sample (overlap) or on every sample that matches (non-overlap degenerates identically).
- Mask all zeros with len_ff>0: every sample after fill matches.
- Reset asserted mid-operation: immediate return to reset values, including config (block disabled until reloaded).

Test Plan:
- Load pat=12'b1110_1101_1011, mask=all ones, len=12, overlap=1. Stream 1110_1101_1011 MSB first with valid every cycle -> det_o=1 exactly one cycle after the 12th bit edge, cnt_o=1, armed_o=1 from the 12th edge.
- len=4, pat=4'b1010, overlap=1, stream 1010101 -> det_o pulses after bits 4 and 6, cnt_o=2. Same stream with overlap=0 -> single pulse after bit 4, cnt_o=1.
- len=4, pat=4'b1010, stream 1010 with valid_i=0 gaps inserted between bits -> still exactly one det_o pulse, aligned to the edge of the 4th valid bit. x_i toggling during gaps has no effect.
- mask=4'b1001, pat=4'b1001, len=4: streams 1001, 1111, 1011 each each produce a match (after fill/restart, non-overlap); stream 0001 does not.
- CNT_W=2, overlap=1, len=1, pat=1, stream 6 ones -> cnt_o saturates at 3. Assert clear_i on a match cycle -> cnt_o=0, det_o=1.
- cfg_load_i mid-stream with valid_i=1 -> sample dropped, armed_o=0, no det_o until len new samples. Drive reset=0 mid-stream -> det_o=0, cnt_o=0, no detection until reloaded.

Source files
------------

// File: rtl/seq_det_prog.sv
// rtl/seq_det_prog.sv - programmable serial sequence detector with masked pattern and saturating match count
module seq_det_prog #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x_i,
    input  logic               valid_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [MAX_LEN-1:0] cfg_mask_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic               clear_i,
    output logic               det_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               armed_o
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_HUNT} state_t;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_shift;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-1:0] r_mask;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_det;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_armed;

    logic [MAX_LEN-1:0] w_nxt;
    logic [MAX_LEN-1:0] w_len_mask;
    logic               w_match;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [LEN_W-1:0]   w_len_new;
    logic               w_eval;
    logic               w_hit;

    assign w_nxt      = {r_shift[MAX_LEN-2:0], x_i};
    assign w_fill_inc = r_fill + 1'b1;
    assign w_len_new  = (cfg_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len_i;

    // Bits at or beyond the programmed length never take part in the compare
    always_comb begin
        w_len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_len_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_match = (((w_nxt ^ r_pat) & r_mask & w_len_mask) == '0);
    // The completing FILL sample is evaluated on the same edge that arms the hunt
    assign w_eval  = valid_i && ((r_state == S_FILL && w_fill_inc == r_len) || r_state == S_HUNT);
    assign w_hit   = w_eval && w_match;

    // Config, shift register, fill count, FSM and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_fill  <= '0;
            r_pat   <= '0;
            r_mask  <= '0;
            r_len   <= '0;
            r_ovl   <= 1'b0;
            r_det   <= 1'b0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_det <= 1'b0;
            if (clear_i) begin
                r_cnt <= '0;
            end
            if (cfg_load_i) begin
                r_pat   <= cfg_pattern_i;
                r_mask  <= cfg_mask_i;
                r_len   <= w_len_new;
                r_ovl   <= cfg_overlap_i;
                r_shift <= '0;
                r_fill  <= '0;
                r_armed <= 1'b0;
                r_state <= (w_len_new == '0) ? S_IDLE : S_FILL;
            end else if (valid_i) begin
                r_shift <= w_nxt;
                if (w_hit) begin
                    r_det <= 1'b1;
                    if (!clear_i && r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                case (r_state)
                    S_FILL: begin
                        if (w_hit && !r_ovl) begin
                            r_fill <= '0;
                        end else begin
                            r_fill <= w_fill_inc;
                            if (w_fill_inc == r_len) begin
                                r_state <= S_HUNT;
                                r_armed <= 1'b1;
                            end
                        end
                    end
                    S_HUNT: begin
                        if (w_hit && !r_ovl) begin
                            r_fill  <= '0;
                            r_state <= S_FILL;
                            r_armed <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign det_o   = r_det;
    assign cnt_o   = r_cnt;
    assign armed_o = r_armed;

endmodule

// File: tb/tb_seq_det_prog.sv
// tb/tb_seq_det_prog.sv - randomized and directed bench for seq_det_prog against a history-based model
module tb_seq_det_prog;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 5;
    localparam int CNT_MAX = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              x_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              cfg_load_i = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern_i = '0;
    logic [MAX_LEN-1:0] cfg_mask_i = '0;
    logic [LEN_W-1:0]  cfg_len_i = '0;
    logic              cfg_overlap_i = 1'b0;
    logic              clear_i = 1'b0;
    logic              det_o;
    logic [CNT_W-1:0]  cnt_o;
    logic              armed_o;

    seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .x_i(x_i), .valid_i(valid_i),
        .cfg_load_i(cfg_load_i), .cfg_pattern_i(cfg_pattern_i), .cfg_mask_i(cfg_mask_i),
        .cfg_len_i(cfg_len_i), .cfg_overlap_i(cfg_overlap_i), .clear_i(clear_i),
        .det_o(det_o), .cnt_o(cnt_o), .armed_o(armed_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // Model: config, bits received since the last load, samples since the last (re)arm
    logic [MAX_LEN-1:0] m_pat, m_mask;
    int   m_len, m_since, m_cnt;
    bit   m_ovl, m_det;
    bit   m_hist[$];

    function automatic bit m_armed();
        return (m_len > 0) && (m_since >= m_len);
    endfunction

    task automatic model_reset();
        m_pat = '0; m_mask = '0; m_len = 0; m_ovl = 0;
        m_since = 0; m_cnt = 0; m_det = 0;
        m_hist.delete();
    endtask

    function automatic bit model_match();
        for (int i = 0; i < m_len; i++) begin
            if (m_mask[i] && (m_hist[m_hist.size()-1-i] != m_pat[i])) return 0;
        end
        return 1;
    endfunction

    // Applies one clock edge worth of input to the model
    task automatic model_edge();
        m_det = 0;
        if (cfg_load_i) begin
            m_pat   = cfg_pattern_i;
            m_mask  = cfg_mask_i;
            m_len   = (int'(cfg_len_i) > MAX_LEN) ? MAX_LEN : int'(cfg_len_i);
            m_ovl   = cfg_overlap_i;
            m_since = 0;
            m_hist.delete();
        end else if (valid_i) begin
            m_hist.push_back(x_i);
            if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
            m_since++;
            if (m_since > m_len) m_since = m_len;
            if (m_len > 0 && m_since >= m_len && model_match()) begin
                m_det = 1;
                if (!m_ovl) m_since = 0;
            end
        end
        if (clear_i) m_cnt = 0;
        else if (m_det && m_cnt < CNT_MAX) m_cnt++;
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        n_checks += 3;
        if (det_o !== m_det) begin
            n_fail++;
            $display("FAIL cyc_det t=%0t got %0b want %0b", $time, det_o, m_det);
        end
        if (cnt_o !== CNT_W'(m_cnt)) begin
            n_fail++;
            $display("FAIL cyc_cnt t=%0t got %0d want %0d", $time, cnt_o, m_cnt);
        end
        if (armed_o !== m_armed()) begin
            n_fail++;
            $display("FAIL cyc_armed t=%0t got %0b want %0b", $time, armed_o, m_armed());
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update model, settle
    task automatic cyc(input logic x, input logic v, input logic ld, input logic clr);
        x_i = x; valid_i = v; cfg_load_i = ld; clear_i = clr;
        @(posedge clk);
        model_edge();
        #1;
        if (det_o === 1'b1) pulses++;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [MAX_LEN-1:0] mask,
                        input int len, input logic ovl, input logic clr);
        cfg_pattern_i = pat; cfg_mask_i = mask; cfg_len_i = LEN_W'(len); cfg_overlap_i = ovl;
        cyc(1'b0, 1'b1, 1'b1, clr);
        pulses = 0;
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(bits[i], 1'b1, 1'b0, 1'b0);
    endtask

    logic [15:0] grp [4];
    int          grp_want [4];

    initial begin
        model_reset();
        #12;
        chk("reset_det", det_o, 0);
        chk("reset_cnt", cnt_o, 0);
        chk("reset_armed", armed_o, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 12-bit pattern, overlap
        load(16'h0EDB, 16'hFFFF, 12, 1'b1, 1'b0);
        send(16'h0ED, 8);
        send(16'h00D, 3);
        chk("p12_pre_det", det_o, 0);
        chk("p12_pre_armed", armed_o, 0);
        send(16'h001, 1);
        chk("p12_det", det_o, 1);
        chk("p12_cnt", cnt_o, 1);
        chk("p12_armed", armed_o, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("p12_det_one_cycle", det_o, 0);

        // 1010 with overlap, then without
        load(16'h000A, 16'hFFFF, 4, 1'b1, 1'b1);
        chk("clr_on_load_cnt", cnt_o, 0);
        send(16'h0055, 7);
        chk("ovl_pulses", pulses, 2);
        chk("ovl_cnt", cnt_o, 2);
        load(16'h000A, 16'hFFFF, 4, 1'b0, 1'b1);
        send(16'h0055, 7);
        chk("novl_pulses", pulses, 1);
        chk("novl_cnt", cnt_o, 1);

        // valid gaps with toggling x
        load(16'h000A, 16'hFFFF, 4, 1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(i[0] ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("gap_det_on_4th", det_o, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap_pulses", pulses, 1);

        // don't-care mask 1001
        load(16'h0009, 16'h0009, 4, 1'b0, 1'b1);
        grp[0] = 16'h9; grp[1] = 16'hF; grp[2] = 16'hB; grp[3] = 16'h1;
        grp_want[0] = 1; grp_want[1] = 1; grp_want[2] = 1; grp_want[3] = 0;
        for (int g = 0; g < 4; g++) begin
            pulses = 0;
            send(grp[g], 4);
            chk("mask_group", pulses, grp_want[g]);
        end

        // saturation and clear on a match
        load(16'h0001, 16'h0001, 1, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_cnt", cnt_o, CNT_MAX);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_match_det", det_o, 1);
        chk("clr_match_cnt", cnt_o, 0);

        // mask all zeros matches every sample after fill
        load(16'h1234, 16'h0000, 3, 1'b1, 1'b1);
        send(16'h0005, 5);
        chk("mask0_pulses", pulses, 3);

        // reload mid-stream drops the sample
        load(16'h000A, 16'hFFFF, 4, 1'b1, 1'b1);
        send(16'h0005, 3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("reload_det", det_o, 0);
        chk("reload_armed", armed_o, 0);
        pulses = 0;
        send(16'h000A, 4);
        chk("reload_pulses", pulses, 1);
        chk("reload_cnt", cnt_o, 1);

        // reset mid-stream clears config
        send(16'h0005, 3);
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_det", det_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_armed", armed_o, 0);
        reset = 1'b1;
        pulses = 0;
        send(16'h000A, 4);
        send(16'h000A, 4);
        chk("rst_nodet", pulses, 0);

        // length clamp
        load(16'h0000, 16'hFFFF, 25, 1'b1, 1'b1);
        send(16'h0000, 15);
        chk("clamp_armed_pre", armed_o, 0);
        send(16'h0000, 1);
        chk("clamp_det", det_o, 1);

        // randomized phase
        for (int blk = 0; blk < 12; blk++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 5);
            load(16'($urandom), 16'($urandom), len, 1'($urandom), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 199) == 0) begin
                    cfg_pattern_i = 16'($urandom); cfg_mask_i = 16'($urandom);
                    cfg_len_i = LEN_W'($urandom_range(0, 6)); cfg_overlap_i = 1'($urandom);
                    cyc(1'($urandom), 1'($urandom), 1'b1, 1'b0);
                end else begin
                    cyc(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 29) == 0));
                end
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
